conv_window_gen: RTL and testbench

- Streaming 3x3 sliding-window generator that sits directly upstream of the 3x3 convolution multiply-accumulate stage.
- Accepts a raster-order 8-bit pixel stream through a valid/ready handshake.
- Buffers the two previous image lines and emits one complete 3x3 neighbourhood per valid output position (no padding, stride 1).
- The downstream convolution stage multiplies the emitted window element-wise with the filter.

---
 rtl/conv_window_gen.sv | 114 +++++++++++
 tb/tb_conv_window_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a shifting
// 3x3 register window, one-deep registered output with valid/ready handoff.
module conv_window_gen #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   pix_in,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic [9*DATA_W-1:0] win_out,
  output logic                win_valid,
  input  logic                win_ready,
  output logic                frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic {FILL, STREAM} state_t;

  state_t                  state;
  logic [CW-1:0]           col_cnt;
  logic [RW-1:0]           row_cnt;
  logic [DATA_W-1:0]       lb0 [IMG_W];
  logic [DATA_W-1:0]       lb1 [IMG_W];
  logic [8:0][DATA_W-1:0]  win_sr;
  logic [8:0][DATA_W-1:0]  win_nxt;
  logic [8:0][DATA_W-1:0]  win_p1;
  logic                    vld_p1;
  logic                    last_p1;
  logic                    accept;
  logic                    handoff;
  logic                    col_end;
  logic                    row_end;
  logic                    win_done;

  // Element 3*r+c holds row r (0 = top), column c (0 = left).
  function automatic logic [8:0][DATA_W-1:0] shift_in(
    input logic [8:0][DATA_W-1:0] win,
    input logic [DATA_W-1:0]      top,
    input logic [DATA_W-1:0]      mid,
    input logic [DATA_W-1:0]      bot
  );
    logic [8:0][DATA_W-1:0] res;
    for (int r = 0; r < 3; r++) begin
      res[3*r]     = win[3*r + 1];
      res[3*r + 1] = win[3*r + 2];
    end
    res[2] = top;
    res[5] = mid;
    res[8] = bot;
    return res;
  endfunction

  assign pix_ready  = !vld_p1 || win_ready;
  assign accept     = pix_valid && pix_ready;
  assign handoff    = vld_p1 && win_ready;
  assign col_end    = (col_cnt == COL_LAST);
  assign row_end    = (row_cnt == ROW_LAST);
  assign win_done   = (state == STREAM) && (col_cnt >= COL_TWO);
  assign win_nxt    = shift_in(win_sr, lb1[col_cnt], lb0[col_cnt], pix_in);
  assign win_out    = win_p1;
  assign win_valid  = vld_p1;
  assign frame_done = handoff && last_p1;

  // Stage p0: line buffers and shifting window; stale contents are masked by row gating
  always_ff @(posedge clk) begin
    if (accept) begin
      win_sr       <= win_nxt;
      lb1[col_cnt] <= lb0[col_cnt];
      lb0[col_cnt] <= pix_in;
    end
  end

  // Stage p1: raster counters, fill/stream state and the output window register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      col_cnt <= '0;
      row_cnt <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      win_p1  <= '0;
    end else begin
      if (accept) begin
        if (col_end) begin
          col_cnt <= '0;
          row_cnt <= row_end ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
        case (state)
          FILL:   if (col_end && row_cnt == ROW_ONE) state <= STREAM;
          STREAM: if (col_end && row_end) state <= FILL;
        endcase
      end
      if (accept && win_done) begin
        vld_p1  <= 1'b1;
        win_p1  <= win_nxt;
        last_p1 <= col_end && row_end;
      end else if (win_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 4x4 and a 16x16 instance driven from a case table,
// windows checked against a position-based reference through a scoreboard queue.
module tb_conv_window_gen;

  typedef struct {
    int w; int h; int base; int frames;
    bit rand_valid; bit rand_ready;
    int stall; int pre_rst; int exp_win; int exp_done;
  } tcase_t;

  typedef struct {
    logic [71:0] win;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        win_ready = 1'b1;
  logic        a_valid, b_valid, a_pready, b_pready, a_wvalid, b_wvalid, a_done, b_done;
  logic [71:0] a_win, b_win;
  logic        m_pready, m_wvalid, m_done;
  logic [71:0] m_win;
  int          n_total = 0;
  int          n_bad = 0;
  tcase_t      cases[5];

  always #5 clk = ~clk;

  assign a_valid  = pix_valid && !sel;
  assign b_valid  = pix_valid && sel;
  assign m_pready = sel ? b_pready : a_pready;
  assign m_wvalid = sel ? b_wvalid : a_wvalid;
  assign m_done   = sel ? b_done   : a_done;
  assign m_win    = sel ? b_win    : a_win;

  conv_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(a_valid), .pix_ready(a_pready),
    .win_out(a_win), .win_valid(a_wvalid), .win_ready(win_ready), .frame_done(a_done));

  conv_window_gen #(.IMG_W(16), .IMG_H(16), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(b_valid), .pix_ready(b_pready),
    .win_out(b_win), .win_valid(b_wvalid), .win_ready(win_ready), .frame_done(b_done));

  task automatic chk_int(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Window whose bottom-right pixel sits at (r, c); pixel value = fb + r*w + c (mod 256).
  function automatic logic [71:0] ref_win(input int w, input int fb, input int r, input int c);
    logic [71:0] v;
    v = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        v[8*(3*rr+cc) +: 8] = 8'((fb + (r - 2 + rr) * w + (c - 2 + cc)) % 256);
    return v;
  endfunction

  task automatic check_in_reset();
    chk_int("reset win_valid", int'(m_wvalid), 0);
    chk_int("reset pix_ready", int'(m_pready), 1);
    chk_int("reset frame_done", int'(m_done), 0);
    chk_win("reset win_out", m_win, '0);
  endtask

  task automatic run_case(input int id, input tcase_t t);
    int   npix, total, idx, cyc, budget, nwin, ndone, stall_left, first_push, first_vld;
    int   p, f, fb, r, c;
    bit   stall_started;
    exp_t q[$];
    exp_t e;
    npix = t.w * t.h;
    total = npix * t.frames;
    idx = 0; cyc = 0; nwin = 0; ndone = 0; stall_left = 0;
    first_push = -1; first_vld = -1; stall_started = 0;
    budget = 30 * total + 200;

    @(negedge clk);
    pix_valid = 1'b0;
    win_ready = 1'b1;
    sel = (t.w == 16);

    // Partial frame, then an asynchronous mid-cycle reset; the frame restarts at (0,0).
    if (t.pre_rst > 0) begin
      for (int i = 0; i < t.pre_rst; i++) begin
        @(negedge clk);
        pix_valid = 1'b1;
        pix_in = 8'(i);
      end
      @(negedge clk);
      pix_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_in_reset();
      @(posedge clk);
      @(negedge clk);
      check_in_reset();
      rst_n = 1'b1;
    end

    while ((idx < total || q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      if (m_wvalid && !stall_started && t.stall > 0) begin
        stall_started = 1;
        stall_left = t.stall;
      end
      if (stall_left > 0) win_ready = 1'b0;
      else win_ready = t.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_valid = (idx < total) && (t.rand_valid ? 1'($urandom_range(0, 1)) : 1'b1);
      p = idx % npix;
      f = idx / npix;
      fb = t.base + f * 100;
      r = p / t.w;
      c = p % t.w;
      pix_in = 8'((fb + p) % 256);
      #1;
      if (stall_left > 0) begin
        chk_int($sformatf("case%0d stall pix_ready", id), int'(m_pready), 0);
        if (q.size() > 0) chk_win($sformatf("case%0d stall win_out", id), m_win, q[0].win);
        stall_left--;
      end
      if (m_wvalid && first_vld < 0) first_vld = cyc;
      if (m_done) ndone++;
      if (m_wvalid && win_ready) begin
        if (q.size() == 0) begin
          chk_int($sformatf("case%0d unexpected window", id), 1, 0);
        end else begin
          e = q.pop_front();
          chk_win($sformatf("case%0d window %0d", id, nwin), m_win, e.win);
          chk_int($sformatf("case%0d frame_done at window %0d", id, nwin), int'(m_done), int'(e.last));
          nwin++;
        end
      end
      if (pix_valid && m_pready) begin
        if (r >= 2 && c >= 2) begin
          e.win = ref_win(t.w, fb, r, c);
          e.last = (r == t.h - 1) && (c == t.w - 1);
          q.push_back(e);
          if (first_push < 0) first_push = cyc;
        end
        idx++;
      end
      cyc++;
    end

    chk_int($sformatf("case%0d finished within budget", id), int'(cyc < budget), 1);
    chk_int($sformatf("case%0d window count", id), nwin, t.exp_win);
    chk_int($sformatf("case%0d frame_done pulses", id), ndone, t.exp_done);
    chk_int($sformatf("case%0d first window latency", id), first_vld, first_push + 1);
    @(negedge clk);
    pix_valid = 1'b0;
    win_ready = 1'b1;
  endtask

  initial begin
    //           w   h   base fr rv rr stall pre win  done
    cases[0] = '{4,  4,  0,   1, 0, 0, 0,    0,  4,   1};
    cases[1] = '{4,  4,  0,   1, 0, 0, 5,    0,  4,   1};
    cases[2] = '{4,  4,  0,   2, 1, 0, 0,    0,  8,   2};
    cases[3] = '{4,  4,  0,   1, 0, 0, 0,    7,  4,   1};
    cases[4] = '{16, 16, 0,   1, 0, 1, 0,    0,  196, 1};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_in_reset();
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_case(i, cases[i]);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
